// File: rtl/atm_f7_port.sv
// rtl/atm_f7_port.sv - ATM xxF7 memory-map port responder: write strobe to pagers plus shadow readback
module atm_f7_port (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        port_ena,
  input  logic        pent1m_ROM,
  output logic        atmF7_wr,
  output logic [15:0] wr_za,
  output logic [7:0]  wr_zd,
  output logic [7:0]  zd_out,
  output logic        zd_out_ena
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WSTB = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_READ = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic        strobe_q, strobe_d;
  logic [15:0] wr_za_q, wr_za_d;
  logic [7:0]  wr_zd_q, wr_zd_d;
  logic [7:0]  zd_out_q, zd_out_d;
  logic        ena_q, ena_d;
  logic [7:0]  shadow_q [0:7];
  logic        sh_we;
  logic [2:0]  sh_idx;
  logic        port_hit, io_ok, wr_cyc, rd_cyc;
  logic        zneg_unused;

  assign zneg_unused = zneg;

  always_comb begin
    port_hit = port_ena && (za[7:0] == 8'hF7) && (za[13:12] == 2'b11) && (za[10:8] == 3'b111);
    io_ok    = !iorq_n && m1_n && port_hit;
    wr_cyc   = io_ok && !wr_n;
    rd_cyc   = io_ok && !rd_n;
    sh_idx   = {za[15:14], pent1m_ROM};

    state_d  = state_q;
    armed_d  = armed_q;
    strobe_d = 1'b0;
    wr_za_d  = wr_za_q;
    wr_zd_d  = wr_zd_q;
    zd_out_d = zd_out_q;
    ena_d    = ena_q;
    sh_we    = 1'b0;

    // An idle bus seen on any zpos re-arms; acceptance disarms until the cycle ends.
    if (zpos && iorq_n) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (zpos && armed_q && wr_cyc) begin
          state_d  = ST_WSTB;
          armed_d  = 1'b0;
          strobe_d = 1'b1;
          wr_za_d  = za;
          wr_zd_d  = zd_in;
          sh_we    = 1'b1;
        end else if (zpos && armed_q && rd_cyc) begin
          state_d  = ST_READ;
          armed_d  = 1'b0;
          ena_d    = 1'b1;
          zd_out_d = shadow_q[sh_idx];
        end
      end
      ST_WSTB: state_d = ST_HOLD;
      ST_HOLD: begin
        if (zpos && iorq_n) state_d = ST_IDLE;
      end
      default: begin
        zd_out_d = shadow_q[sh_idx];
        if (zpos && (iorq_n || rd_n)) begin
          state_d = ST_IDLE;
          ena_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b0;
      strobe_q <= 1'b0;
      wr_za_q  <= 16'h0000;
      wr_zd_q  <= 8'h00;
      zd_out_q <= 8'h00;
      ena_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      strobe_q <= strobe_d;
      wr_za_q  <= wr_za_d;
      wr_zd_q  <= wr_zd_d;
      zd_out_q <= zd_out_d;
      ena_q    <= ena_d;
    end
  end

  // Reset contents mirror the pagers' power-up pages in 1 MB encoding; index = {window, map}.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q[0] <= 8'h81;
      shadow_q[1] <= 8'h83;
      shadow_q[2] <= 8'h7A;
      shadow_q[3] <= 8'h7A;
      shadow_q[4] <= 8'h7D;
      shadow_q[5] <= 8'h7D;
      shadow_q[6] <= 8'hFF;
      shadow_q[7] <= 8'hFF;
    end else if (sh_we) begin
      shadow_q[sh_idx] <= zd_in;
    end
  end

  assign atmF7_wr   = strobe_q;
  assign wr_za      = wr_za_q;
  assign wr_zd      = wr_zd_q;
  assign zd_out     = zd_out_q;
  assign zd_out_ena = ena_q;

endmodule

// File: tb/tb_atm_f7_port.sv
// tb/tb_atm_f7_port.sv - scoreboard bench for atm_f7_port
module tb_atm_f7_port;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        zpos, zneg;
  logic [15:0] za;
  logic [7:0]  zd_in;
  logic        iorq_n, rd_n, wr_n, m1_n;
  logic        port_ena, pent1m_ROM;
  logic        atmF7_wr;
  logic [15:0] wr_za;
  logic [7:0]  wr_zd, zd_out;
  logic        zd_out_ena;

  logic [1:0]  zcnt = 2'd0;
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  int          rd_cnt = 0;
  logic        prev_wr = 1'b0;
  logic        prev_ena = 1'b0;

  typedef struct {
    bit          is_wr;
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t sb[$];

  atm_f7_port dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .za(za), .zd_in(zd_in),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .port_ena(port_ena), .pent1m_ROM(pent1m_ROM),
    .atmF7_wr(atmF7_wr), .wr_za(wr_za), .wr_zd(wr_zd),
    .zd_out(zd_out), .zd_out_ena(zd_out_ena)
  );

  always #10 fclk = ~fclk;
  always @(posedge fclk) zcnt <= zcnt + 2'd1;
  assign zpos = (zcnt == 2'd3);
  assign zneg = (zcnt == 2'd1);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and every readback start.
  always @(negedge fclk) begin
    if (!rst_n) begin
      prev_wr  = 1'b0;
      prev_ena = 1'b0;
    end else begin
      if (atmF7_wr) begin
        strobe_cnt++;
        chk("strobe_width", {15'd0, prev_wr}, 16'd0);
        if (sb.size() == 0 || !sb[0].is_wr) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe actual=%h expected=none", wr_za);
        end else begin
          chk("wr_za", wr_za, sb[0].a);
          chk("wr_zd", {8'd0, wr_zd}, {8'd0, sb[0].d});
          void'(sb.pop_front());
        end
      end
      if (zd_out_ena && !prev_ena) begin
        rd_cnt++;
        if (sb.size() == 0 || sb[0].is_wr) begin
          checks++; failures++;
          $display("FAIL unexpected_readback actual=%h expected=none", zd_out);
        end else begin
          chk("zd_out", {8'd0, zd_out}, {8'd0, sb[0].d});
          void'(sb.pop_front());
        end
      end
      prev_wr  = atmF7_wr;
      prev_ena = zd_out_ena;
    end
  end

  // Returns just after the fclk edge on which the DUT sampled zpos=1.
  task automatic zedge();
    @(negedge fclk);
    while (!zpos) @(negedge fclk);
    @(posedge fclk);
    #1;
  endtask

  task automatic io_cycle(input logic [15:0] a, input logic [7:0] d, input bit wr,
                          input int len, input bit m1, input bit hit, input logic [7:0] exp_rd);
    int s0, r0;
    exp_t e;
    s0 = strobe_cnt;
    r0 = rd_cnt;
    if (hit) begin
      e.is_wr = wr; e.a = a; e.d = wr ? d : exp_rd;
      sb.push_back(e);
    end
    za = a; zd_in = d; m1_n = m1; iorq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    repeat (len) zedge();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (2) zedge();
    chk(wr ? "strobe_count" : "read_count",
        wr ? 16'(strobe_cnt - s0) : 16'(rd_cnt - r0), hit ? 16'd1 : 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; za = 16'h0000; zd_in = 8'h00;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    port_ena = 1'b1; pent1m_ROM = 1'b0;
    repeat (5) @(posedge fclk);
    #1 rst_n = 1'b1;
    chk("rst_atmF7_wr", {15'd0, atmF7_wr}, 16'd0);
    chk("rst_wr_za", wr_za, 16'h0000);
    chk("rst_wr_zd", {8'd0, wr_zd}, 16'h0000);
    chk("rst_zd_out", {8'd0, zd_out}, 16'h0000);
    chk("rst_zd_out_ena", {15'd0, zd_out_ena}, 16'd0);
    repeat (2) zedge();

    io_cycle(16'h3FF7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h81);
    pent1m_ROM = 1'b1;
    io_cycle(16'h3FF7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h83);
    pent1m_ROM = 1'b0;
    io_cycle(16'hFFF7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'hFF);

    io_cycle(16'h7FF7, 8'h47, 1'b1, 4, 1'b1, 1'b1, 8'h00);
    io_cycle(16'h7FF7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h47);

    pent1m_ROM = 1'b1;
    io_cycle(16'hB7F7, 8'hC0, 1'b1, 3, 1'b1, 1'b1, 8'h00);
    pent1m_ROM = 1'b0;
    io_cycle(16'hB7F7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h7D);
    pent1m_ROM = 1'b1;
    io_cycle(16'hB7F7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'hC0);
    pent1m_ROM = 1'b0;

    io_cycle(16'h3EF7, 8'h55, 1'b1, 3, 1'b1, 1'b0, 8'h00);
    port_ena = 1'b0;
    io_cycle(16'hBFF7, 8'h66, 1'b1, 3, 1'b1, 1'b0, 8'h00);
    io_cycle(16'hBFF7, 8'h00, 1'b0, 3, 1'b1, 1'b0, 8'h00);
    port_ena = 1'b1;

    io_cycle(16'h3FF7, 8'h00, 1'b0, 3, 1'b0, 1'b0, 8'h00);
    io_cycle(16'h3FF7, 8'h99, 1'b1, 3, 1'b0, 1'b0, 8'h00);

    // Reset asserted and released while a write cycle holds iorq_n low.
    begin
      int s0;
      s0 = strobe_cnt;
      za = 16'h7FF7; zd_in = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
      zedge();
      rst_n = 1'b0;
      repeat (2) zedge();
      rst_n = 1'b1;
      repeat (3) zedge();
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (2) zedge();
      chk("rst_midcycle_strobe", 16'(strobe_cnt - s0), 16'd0);
      chk("rst_midcycle_wr_za", wr_za, 16'h0000);
    end
    io_cycle(16'h7FF7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h7A);
    io_cycle(16'hB7F7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h7D);
    io_cycle(16'h7FF7, 8'h22, 1'b1, 5, 1'b1, 1'b1, 8'h00);
    io_cycle(16'h77F7, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h22);

    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
